// File: rtl/awaddr_ddr_sched_if.sv
// AXI write-address and write-response channel between the awaddr scheduler and the DDR controller.
// The master modport is the scheduler side, the slave modport is the controller side.
interface awaddr_ddr_sched_if #(
   parameter int ID_WIDTH   = 2,
   parameter int ADDR_WIDTH = 28,
   parameter int LEN_WIDTH  = 8
);
   logic                  m_awvalid;
   logic                  m_awready;
   logic [ADDR_WIDTH-1:0] m_awaddr;
   logic [LEN_WIDTH-1:0]  m_awlen;
   logic [ID_WIDTH-1:0]   m_awid;
   logic                  m_bvalid;
   logic                  m_bready;

   modport master (
      output m_awvalid, m_awaddr, m_awlen, m_awid, m_bready,
      input  m_awready, m_bvalid
   );

   modport slave (
      input  m_awvalid, m_awaddr, m_awlen, m_awid, m_bready,
      output m_awready, m_bvalid
   );
endinterface

// File: rtl/awaddr_ddr_sched.sv
// Round-robin push of per-channel burst requests into the awaddr FIFO, and a fetch/load/issue
// pop engine that drives the AXI AW channel while limiting bursts awaiting a B response.
module awaddr_ddr_sched #(
   parameter int NUM_CH     = 4,
   parameter int ID_WIDTH   = 2,
   parameter int ADDR_WIDTH = 28,
   parameter int LEN_WIDTH  = 8,
   parameter int MAX_OUTST  = 4,
   localparam int FIFO_DW   = ID_WIDTH + LEN_WIDTH + ADDR_WIDTH
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_CH-1:0]              req_valid,
   output logic [NUM_CH-1:0]              req_ready,
   input  logic [NUM_CH*ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_CH*LEN_WIDTH-1:0]    req_len,
   output logic                           fifo_wr_en,
   output logic [FIFO_DW-1:0]             fifo_wr_data,
   input  logic                           fifo_wr_full,
   output logic                           fifo_rd_en,
   input  logic [FIFO_DW-1:0]             fifo_rd_data,
   input  logic                           fifo_rd_empty,
   awaddr_ddr_sched_if.master             axi,
   output logic [3:0]                     outst_cnt,
   output logic                           err_b_underflow
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_ISSUE
   } state_t;

   state_t                state_reg, state_next;
   logic [ID_WIDTH-1:0]   rr_ptr_reg, rr_ptr_next;
   logic [3:0]            outst_reg, outst_next;
   logic                  err_reg;
   logic                  bready_reg;
   logic                  awvalid_reg;
   logic [ID_WIDTH-1:0]   awid_reg;
   logic [LEN_WIDTH-1:0]  awlen_reg;
   logic [ADDR_WIDTH-1:0] awaddr_reg;

   logic [ADDR_WIDTH-1:0] ch_addr [NUM_CH];
   logic [LEN_WIDTH-1:0]  ch_len  [NUM_CH];
   logic [NUM_CH-1:0]     upper_mask;
   logic [NUM_CH-1:0]     upper_req;
   logic [NUM_CH-1:0]     pick_vec;
   logic [ID_WIDTH-1:0]   grant_idx;
   logic                  grant_any;
   logic                  push_en;

   logic                  aw_fire;
   logic                  b_fire;
   logic                  b_dec;
   logic                  room_now;
   logic                  room_post;
   logic                  rd_en;
   logic                  load_en;

   // Channels at or above the pointer get first pick; if none of them request, wrap to the rest.
   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign ch_addr[gi]    = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign ch_len[gi]     = req_len[gi*LEN_WIDTH +: LEN_WIDTH];
         assign upper_mask[gi] = (ID_WIDTH'(gi) >= rr_ptr_reg);
      end
   endgenerate

   assign upper_req = req_valid & upper_mask;
   assign pick_vec  = (|upper_req) ? upper_req : req_valid;

   always_comb begin
      grant_idx = '0;
      grant_any = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (pick_vec[i]) begin
            grant_idx = ID_WIDTH'(i);
            grant_any = 1'b1;
         end
      end
   end

   // bready_reg doubles as the "out of reset" flag so nothing is pushed while the FIFO is held in reset.
   assign push_en      = grant_any && !fifo_wr_full && bready_reg;
   assign req_ready    = push_en ? (NUM_CH'(1) << grant_idx) : '0;
   assign fifo_wr_en   = push_en;
   assign fifo_wr_data = push_en ? {grant_idx, ch_len[grant_idx], ch_addr[grant_idx]} : '0;

   always_comb begin
      rr_ptr_next = rr_ptr_reg;
      if (push_en) begin
         rr_ptr_next = (grant_idx == ID_WIDTH'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   assign aw_fire = (state_reg == ST_ISSUE) && awvalid_reg && axi.m_awready;
   assign b_fire  = axi.m_bvalid && bready_reg;
   assign b_dec   = b_fire && (outst_reg != 4'd0);

   always_comb begin
      outst_next = outst_reg;
      if (aw_fire && !b_dec) begin
         outst_next = outst_reg + 4'd1;
      end else if (!aw_fire && b_dec) begin
         outst_next = outst_reg - 4'd1;
      end
   end

   assign room_now  = (outst_reg  < 4'(MAX_OUTST));
   assign room_post = (outst_next < 4'(MAX_OUTST));

   always_comb begin
      state_next = state_reg;
      rd_en      = 1'b0;
      load_en    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (!fifo_rd_empty && room_now) begin
               state_next = ST_FETCH;
            end
         end
         ST_FETCH: begin
            rd_en      = 1'b1;
            state_next = ST_LOAD;
         end
         ST_LOAD: begin
            load_en    = 1'b1;
            state_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (aw_fire) begin
               state_next = (!fifo_rd_empty && room_post) ? ST_FETCH : ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         rr_ptr_reg  <= '0;
         outst_reg   <= 4'd0;
         err_reg     <= 1'b0;
         bready_reg  <= 1'b0;
         awvalid_reg <= 1'b0;
         awid_reg    <= '0;
         awlen_reg   <= '0;
         awaddr_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         rr_ptr_reg <= rr_ptr_next;
         outst_reg  <= outst_next;
         bready_reg <= 1'b1;
         if (b_fire && (outst_reg == 4'd0)) begin
            err_reg <= 1'b1;
         end
         if (load_en) begin
            awvalid_reg <= 1'b1;
            {awid_reg, awlen_reg, awaddr_reg} <= fifo_rd_data;
         end else if (aw_fire) begin
            awvalid_reg <= 1'b0;
         end
      end
   end

   assign fifo_rd_en      = rd_en;
   assign axi.m_awvalid   = awvalid_reg;
   assign axi.m_awid      = awid_reg;
   assign axi.m_awlen     = awlen_reg;
   assign axi.m_awaddr    = awaddr_reg;
   assign axi.m_bready    = bready_reg;
   assign outst_cnt       = outst_reg;
   assign err_b_underflow = err_reg;

endmodule

// File: tb/tb_awaddr_ddr_sched.sv
// Bench for awaddr_ddr_sched: a queue-based FIFO, a transaction-level reference model checked every
// cycle, and directed scenarios with hand-computed expectations.
module tb_awaddr_ddr_sched;
   localparam int NCH = 4;
   localparam int IDW = 2;
   localparam int AW  = 28;
   localparam int LW  = 8;
   localparam int MO  = 4;
   localparam int DW  = IDW + LW + AW;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [NCH-1:0]  req_valid = '0;
   logic [NCH-1:0]  req_ready;
   logic [NCH*AW-1:0] req_addr = '0;
   logic [NCH*LW-1:0] req_len = '0;
   logic            fifo_wr_en;
   logic [DW-1:0]   fifo_wr_data;
   logic            fifo_wr_full;
   logic            fifo_rd_en;
   logic [DW-1:0]   fifo_rd_data;
   logic            fifo_rd_empty;
   logic [3:0]      outst_cnt;
   logic            err_b_underflow;
   logic            force_full = 1'b0;

   awaddr_ddr_sched_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) axi ();

   awaddr_ddr_sched #(
      .NUM_CH(NCH), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MAX_OUTST(MO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
      .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_wr_full(fifo_wr_full),
      .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
      .axi(axi), .outst_cnt(outst_cnt), .err_b_underflow(err_b_underflow)
   );

   always #5 clk = ~clk;

   // Synchronous FIFO, 16 deep, read data one cycle after rd_en.
   logic [DW-1:0] fmem [16];
   logic [3:0]    wp, rp;
   logic [4:0]    fcnt;
   logic          f_w, f_r;
   assign f_w           = fifo_wr_en && !fifo_wr_full;
   assign f_r           = fifo_rd_en && (fcnt != 5'd0);
   assign fifo_rd_empty = (fcnt == 5'd0);
   assign fifo_wr_full  = force_full || (fcnt == 5'd16);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp <= '0; rp <= '0; fcnt <= '0; fifo_rd_data <= '0;
      end else begin
         if (f_w) begin
            fmem[wp] <= fifo_wr_data;
            wp <= wp + 4'd1;
         end
         if (f_r) begin
            fifo_rd_data <= fmem[rp];
            rp <= rp + 4'd1;
         end
         fcnt <= fcnt + {4'd0, f_w} - {4'd0, f_r};
      end
   end

   logic tb_run;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) tb_run <= 1'b0;
      else        tb_run <= 1'b1;
   end

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // Reference model: expected push grant, expected AW order, outstanding count and error flag.
   int            m_rr = 0;
   int            m_outst = 0;
   logic          m_err = 1'b0;
   logic [DW-1:0] exp_aw [$];
   logic          hold_v = 1'b0;
   logic [DW-1:0] hold_w = '0;
   int            n_aw = 0;

   always @(negedge clk) begin
      logic          found;
      int            g;
      int            k;
      logic          push;
      logic [DW-1:0] word;
      logic [DW-1:0] aw_word;
      logic          hs;
      logic          bf;
      if (!rst_n) begin
         m_rr = 0; m_outst = 0; m_err = 1'b0; hold_v = 1'b0;
         exp_aw.delete();
      end else begin
         found = 1'b0; g = 0;
         for (int i = 0; i < NCH; i++) begin
            k = (m_rr + i) % NCH;
            if (!found && req_valid[k]) begin found = 1'b1; g = k; end
         end
         push = tb_run && !fifo_wr_full && found;
         check("m_req_ready", req_ready, push ? (64'd1 << g) : 64'd0);
         check("m_wr_en", fifo_wr_en, push);
         if (push) begin
            word = {IDW'(g), req_len[g*LW +: LW], req_addr[g*AW +: AW]};
            check("m_wr_data", fifo_wr_data, word);
            exp_aw.push_back(word);
            m_rr = (g + 1) % NCH;
         end
         check("m_bready", axi.m_bready, tb_run);
         check("m_outst", outst_cnt, m_outst);
         check("m_err", err_b_underflow, m_err);
         if (fifo_rd_en) check("m_rd_not_empty", fifo_rd_empty, 1'b0);
         aw_word = {axi.m_awid, axi.m_awlen, axi.m_awaddr};
         if (axi.m_awvalid) begin
            if (hold_v) check("m_aw_stable", aw_word, hold_w);
            if (axi.m_awready) begin
               if (exp_aw.size() == 0) begin
                  check("m_aw_unexpected", 1'b1, 1'b0);
               end else begin
                  check("m_aw_payload", aw_word, exp_aw[0]);
                  void'(exp_aw.pop_front());
               end
               $display("aw id=%0d len=%0d addr=%0h", axi.m_awid, axi.m_awlen, axi.m_awaddr);
               n_aw++;
               hold_v = 1'b0;
            end else begin
               hold_v = 1'b1;
               hold_w = aw_word;
            end
         end
         hs = axi.m_awvalid && axi.m_awready;
         bf = axi.m_bvalid && axi.m_bready;
         if (bf && m_outst == 0) m_err = 1'b1;
         m_outst = m_outst + (hs ? 1 : 0) - ((bf && m_outst > 0) ? 1 : 0);
         check("m_outst_limit", outst_cnt <= 4'(MO), 1'b1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int ch, input logic [AW-1:0] a, input logic [LW-1:0] l);
      req_addr[ch*AW +: AW] = a;
      req_len[ch*LW +: LW]  = l;
   endtask

   // Issue everything queued and retire every outstanding burst; requires 4 quiet cycles in a row.
   task automatic drain();
      int n;
      int quiet;
      n = 0; quiet = 0;
      axi.m_awready = 1'b1;
      while (n < 400 && quiet < 4) begin
         tick();
         axi.m_bvalid = (outst_cnt != 4'd0);
         if (fcnt == 5'd0 && !axi.m_awvalid && outst_cnt == 4'd0 && !axi.m_bvalid) quiet++;
         else quiet = 0;
         n++;
      end
      axi.m_bvalid = 1'b0;
      check("drain_done", quiet >= 4, 1'b1);
      check("drain_all_issued", exp_aw.size(), 0);
   endtask

   logic [NCH-1:0] rr_exp  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [IDW-1:0] rr_ids  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
   logic           lat_rd  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
   logic           lat_av  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      int base;
      int n;
      axi.m_awready = 1'b0;
      axi.m_bvalid  = 1'b0;
      // Reset with every channel requesting and the FIFO full.
      req_valid  = 4'b1111;
      force_full = 1'b1;
      for (int c = 0; c < NCH; c++) set_req(c, AW'(28'h0010000 * (c + 1)), LW'(c + 3));
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", req_ready, 4'b0000);
      check("rst_wr_en", fifo_wr_en, 1'b0);
      check("rst_wr_data", fifo_wr_data, '0);
      check("rst_rd_en", fifo_rd_en, 1'b0);
      check("rst_awvalid", axi.m_awvalid, 1'b0);
      check("rst_aw_payload", {axi.m_awid, axi.m_awlen, axi.m_awaddr}, '0);
      check("rst_bready", axi.m_bready, 1'b0);
      check("rst_outst", outst_cnt, 4'd0);
      check("rst_err", err_b_underflow, 1'b0);
      #1 rst_n = 1'b1;
      #1 check("rel_bready_before_edge", axi.m_bready, 1'b0);
      tick();
      check("rel_bready_after_edge", axi.m_bready, 1'b1);

      // Round-robin over four always-valid channels.
      force_full = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("rr_ready", req_ready, rr_exp[i]);
         check("rr_id", fifo_wr_data[DW-1 -: IDW], rr_ids[i]);
         tick();
      end
      req_valid = '0;
      drain();

      // FIFO-full stall with only channel 2 requesting.
      force_full = 1'b1;
      req_valid  = 4'b0100;
      set_req(2, 28'h0ABCDE0, 8'd7);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("full_ready", req_ready, 4'b0000);
         check("full_wr_en", fifo_wr_en, 1'b0);
         tick();
      end
      force_full = 1'b0;
      @(negedge clk);
      check("unfull_ready", req_ready, 4'b0100);
      check("unfull_wr_en", fifo_wr_en, 1'b1);
      check("unfull_id", fifo_wr_data[DW-1 -: IDW], 2'd2);
      tick();
      req_valid = '0;
      drain();

      // Issue latency from an empty FIFO, then AW held under back-pressure.
      axi.m_awready = 1'b0;
      req_valid = 4'b0010;
      set_req(1, 28'h1000000, 8'd15);
      @(negedge clk);
      check("lat_push", fifo_wr_en, 1'b1);
      tick();
      req_valid = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("lat_rd_en", fifo_rd_en, lat_rd[i]);
         check("lat_awvalid", axi.m_awvalid, lat_av[i]);
      end
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         check("hold_awvalid", axi.m_awvalid, 1'b1);
         check("hold_awid", axi.m_awid, 2'd1);
         check("hold_awlen", axi.m_awlen, 8'd15);
         check("hold_awaddr", axi.m_awaddr, 28'h1000000);
      end
      tick();
      axi.m_awready = 1'b1;
      tick();
      axi.m_awready = 1'b0;
      @(negedge clk);
      check("lat_after_awvalid", axi.m_awvalid, 1'b0);
      check("lat_after_outst", outst_cnt, 4'd1);
      tick();
      drain();

      // Outstanding limit with six queued entries and no responses.
      axi.m_awready = 1'b0;
      for (int j = 0; j < 6; j++) begin
         req_valid = NCH'(1) << (j % NCH);
         set_req(j % NCH, AW'(28'h0001040 + j * 28'h1000), LW'(j));
         tick();
      end
      req_valid = '0;
      base = n_aw;
      axi.m_awready = 1'b1;
      repeat (40) tick();
      check("lim_aw_count", n_aw - base, 4);
      check("lim_outst", outst_cnt, 4'd4);
      check("lim_awvalid", axi.m_awvalid, 1'b0);
      axi.m_bvalid = 1'b1;
      tick();
      axi.m_bvalid = 1'b0;
      repeat (10) tick();
      check("lim_5th_count", n_aw - base, 5);
      check("lim_5th_outst", outst_cnt, 4'd4);
      axi.m_awready = 1'b0;
      axi.m_bvalid = 1'b1;
      tick();
      axi.m_bvalid = 1'b0;
      n = 0;
      while (!axi.m_awvalid && n < 30) begin
         tick();
         n++;
      end
      check("coin_6th_valid", axi.m_awvalid, 1'b1);
      check("coin_before", outst_cnt, 4'd3);
      axi.m_awready = 1'b1;
      axi.m_bvalid  = 1'b1;
      tick();
      axi.m_awready = 1'b0;
      axi.m_bvalid  = 1'b0;
      @(negedge clk);
      check("coin_after", outst_cnt, 4'd3);
      check("coin_count", n_aw - base, 6);
      tick();
      drain();

      // Response with nothing outstanding.
      check("uf_err_before", err_b_underflow, 1'b0);
      axi.m_bvalid = 1'b1;
      tick();
      axi.m_bvalid = 1'b0;
      @(negedge clk);
      check("uf_err", err_b_underflow, 1'b1);
      check("uf_outst", outst_cnt, 4'd0);
      repeat (5) tick();
      @(negedge clk);
      check("uf_sticky", err_b_underflow, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end
endmodule
